regfile_rename: RTL
===================

// Module: regfile_rename
// PURPOSE
//  Architectural register file with per-register rename tags; sits downstream of the ROB commit port.
//  Decoder reads operands and rename status here; on issue it tags rd with the allocated ROB id.
//  ROB commit writes the value back and releases the tag.
//  A mispredict flush (clear_all) drops all pending tags.
// PARAMETERS
//  REG_ID_BIT     5   width of architectural register index (32 regs)
//  ROB_WIDTH_BIT  4   width of ROB id / rename tag
//  XLEN           32  data width
// PORTS
//  clk_in          in   1    clock, posedge
//  rst_in          in   1    reset: asynchronous, active-low
//  rdy_in          in   1    global enable; low = hold all state
//  write_en        in   1    ROB commit valid
//  reg_id          in   5    commit destination register
//  rob_id          in   4    ROB id of committing entry
//  value_out       in   32   commit value
//  rename_en       in   1    decoder issues an instr with rd
//  rename_rd       in   5    rd being renamed
//  rename_tag      in   4    ROB id allocated (ROB rob_free_id)
//  clear_all       in   1    flush: drop all rename tags
//  rs1, rs2        in   5    decoder operand indices
//  rs1_value/rs2_value   out 32  register values
//  rs1_busy/rs2_busy     out 1   operand pending in ROB
//  rs1_reorder/rs2_reorder out 4 pending ROB id (drives ROB reoder_1/2)
//  c_rs1, c_rs2 ... c_rs2_reorder  same set for compressed-decode read group
//  commit_cnt      out  32   retired-write counter (debug)
// BEHAVIOUR
//  Reset (rst_in=0, async): all value=0, busy=0, tag=0, commit_cnt=0.
//  rdy_in=0: no state update; read outputs stay combinational.
//  Reads: combinational, 0 cycles latency, four identical ports.
//  Reads reflect pre-edge state plus commit bypass.
//  Commit bypass: if write_en && reg_id==rsX && busy[rsX] && tag[rsX]==rob_id,
//   then value=value_out and busy=0.
//  A rename in the same cycle is NOT visible to reads (same-instr rs==rd sees old mapping).
//  x0: reads always value 0, busy 0, reorder 0; writes and renames to x0 ignored.
//  Commit (write_en, reg_id!=0): value[reg_id]<=value_out unconditionally.
//   Clear busy[reg_id] only when tag[reg_id]==rob_id; an older commit never clears a newer rename.
//   commit_cnt +1 (wraps at 2^32).
//  Rename (rename_en, rename_rd!=0, !clear_all): busy<=1, tag<=rename_tag.
//  Commit+rename, same reg, same cycle: rename wins for busy/tag; value still written.
//  clear_all: all busy<=0 next edge.
//   A concurrent commit still writes its value; a concurrent rename is dropped.
//  Priority per register: clear_all > rename > commit-release.
//  No FSM; per-register state is the 2-state pair {idle, pending(tag)}.
// STRUCTURE
//  Shared const.v: REG_ID_BIT, ROB_WIDTH_BIT, ROB_WIDTH.
//  One sub-module: regfile_read_port (bypass mux), instantiated 4x.
// TESTING
//  1 Reset mid-run with busy regs.
//    -> all outputs 0 immediately (async), busy 0 after release.
//  2 Rename x5 tag 3, then commit reg 5 rob 3 val 0xDEAD.
//    -> bypass read gives 0xDEAD busy 0 that cycle; busy 0 next cycle.
//  3 Rename x5 tag 3, rename x5 tag 7, commit rob 3 val 1.
//    -> value 1, busy 1, reorder 7.
//  4 Same-cycle commit x6 rob 2 + rename x6 tag 4.
//    -> next cycle busy 1, reorder 4, value = committed.
//  5 clear_all with x1..x31 busy + rename x9 tag 1.
//    -> next cycle all busy 0, x9 not renamed.
//  6 Write/rename x0 with 0xFFFF, rdy_in=0 during commit.
//    -> x0 reads 0; held commit has no effect and commit_cnt is unchanged.

Source files
------------

// File: rtl/regfile_rename_pkg.sv
// Shared widths and per-register state record for the renaming register file.
package regfile_rename_pkg;
  localparam int REG_ID_BIT    = 5;
  localparam int ROB_WIDTH_BIT = 4;
  localparam int XLEN          = 32;
  localparam int NUM_REGS      = 1 << REG_ID_BIT;

  typedef logic [REG_ID_BIT-1:0]    reg_id_t;
  typedef logic [ROB_WIDTH_BIT-1:0] rob_id_t;
  typedef logic [XLEN-1:0]          word_t;

  // One architectural register: idle when busy=0, pending on ROB entry tag otherwise.
  typedef struct packed {
    logic    busy;
    rob_id_t tag;
    word_t   value;
  } reg_entry_t;
endpackage

// File: rtl/regfile_read_port.sv
// One combinational operand read port with same-cycle ROB commit bypass.
module regfile_read_port
  import regfile_rename_pkg::*;
(
  input  reg_id_t    rs_i,
  input  reg_entry_t entry_i,
  input  logic       write_en_i,
  input  reg_id_t    reg_id_i,
  input  rob_id_t    rob_id_i,
  input  word_t      value_i,
  output word_t      value_o,
  output logic       busy_o,
  output rob_id_t    reorder_o
);
  logic bypass_hit;

  // NOTE: every output gets a default first so no path through the block infers a latch.
  always_comb begin
    value_o    = entry_i.value;
    busy_o     = entry_i.busy;
    reorder_o  = entry_i.tag;
    bypass_hit = write_en_i && (reg_id_i == rs_i) && entry_i.busy && (entry_i.tag == rob_id_i);
    if (rs_i == '0) begin
      value_o   = '0;
      busy_o    = 1'b0;
      reorder_o = '0;
    end else if (bypass_hit) begin
      value_o = value_i;
      busy_o  = 1'b0;
    end
  end
endmodule

// File: rtl/regfile_rename.sv
// Architectural register file with per-register ROB rename tags, commit write-back and flush.
module regfile_rename
  import regfile_rename_pkg::*;
(
  input  logic    clk_in,
  input  logic    rst_in,
  input  logic    rdy_in,
  input  logic    write_en,
  input  reg_id_t reg_id,
  input  rob_id_t rob_id,
  input  word_t   value_out,
  input  logic    rename_en,
  input  reg_id_t rename_rd,
  input  rob_id_t rename_tag,
  input  logic    clear_all,
  input  reg_id_t rs1,
  input  reg_id_t rs2,
  output word_t   rs1_value,
  output logic    rs1_busy,
  output rob_id_t rs1_reorder,
  output word_t   rs2_value,
  output logic    rs2_busy,
  output rob_id_t rs2_reorder,
  input  reg_id_t c_rs1,
  input  reg_id_t c_rs2,
  output word_t   c_rs1_value,
  output logic    c_rs1_busy,
  output rob_id_t c_rs1_reorder,
  output word_t   c_rs2_value,
  output logic    c_rs2_busy,
  output rob_id_t c_rs2_reorder,
  output word_t   commit_cnt
);
  reg_entry_t regs_q [NUM_REGS];
  word_t      commit_cnt_q;

  // NOTE: the register array is reset explicitly because every value must read 0 out of reset.
  // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
      commit_cnt_q <= '0;
    end else if (rdy_in) begin
      // x0 is skipped so it stays at its reset value forever.
      for (int i = 1; i < NUM_REGS; i++) begin
        if (write_en && reg_id == reg_id_t'(i)) regs_q[i].value <= value_out;
        if (clear_all) begin
          regs_q[i].busy <= 1'b0;
        end else if (rename_en && rename_rd == reg_id_t'(i)) begin
          regs_q[i].busy <= 1'b1;
          regs_q[i].tag  <= rename_tag;
        end else if (write_en && reg_id == reg_id_t'(i) && regs_q[i].tag == rob_id) begin
          regs_q[i].busy <= 1'b0;
        end
      end
      if (write_en && reg_id != '0) commit_cnt_q <= commit_cnt_q + 1'b1;
    end
  end

  assign commit_cnt = commit_cnt_q;

  regfile_read_port u_rs1 (
    .rs_i(rs1), .entry_i(regs_q[rs1]), .write_en_i(write_en), .reg_id_i(reg_id),
    .rob_id_i(rob_id), .value_i(value_out),
    .value_o(rs1_value), .busy_o(rs1_busy), .reorder_o(rs1_reorder)
  );
  regfile_read_port u_rs2 (
    .rs_i(rs2), .entry_i(regs_q[rs2]), .write_en_i(write_en), .reg_id_i(reg_id),
    .rob_id_i(rob_id), .value_i(value_out),
    .value_o(rs2_value), .busy_o(rs2_busy), .reorder_o(rs2_reorder)
  );
  regfile_read_port u_c_rs1 (
    .rs_i(c_rs1), .entry_i(regs_q[c_rs1]), .write_en_i(write_en), .reg_id_i(reg_id),
    .rob_id_i(rob_id), .value_i(value_out),
    .value_o(c_rs1_value), .busy_o(c_rs1_busy), .reorder_o(c_rs1_reorder)
  );
  regfile_read_port u_c_rs2 (
    .rs_i(c_rs2), .entry_i(regs_q[c_rs2]), .write_en_i(write_en), .reg_id_i(reg_id),
    .rob_id_i(rob_id), .value_i(value_out),
    .value_o(c_rs2_value), .busy_o(c_rs2_busy), .reorder_o(c_rs2_reorder)
  );
endmodule
